button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 650000, is the number of consecutive cycles a synchronized input must differ from its debounced level before that level changes.
REQ-002 Parameter REPEAT_DELAY, default 19500000, is the number of cycles from a debounced press to the first auto-repeat step.
REQ-003 Parameter REPEAT_PERIOD, default 3250000, is the number of cycles between successive auto-repeat steps.
REQ-004 Port clk_in, input, 1 bit, is the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rst_n_in, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-006 Port btn_in, input, 4 bits, carries the raw asynchronous buttons: bit0=btnl, bit1=btnr, bit2=btnu, bit3=btnd.
REQ-007 Port held_out, output, 4 bits, carries the debounced level per button.
REQ-008 Port press_out, output, 4 bits, carries a one-cycle pulse per button on each debounced press.
REQ-009 Port step_out, output, 4 bits, carries a one-cycle pulse per button on the press and on every auto-repeat; this is the motion-step strobe consumed by user_control.

Function
REQ-010 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Debounce counter, per button, width $clog2(DEBOUNCE_CYCLES+1):
  - sync bit equals held level: counter clears to 0.
  - sync bit differs: counter increments.
  - counter reaches DEBOUNCE_CYCLES-1 while sync bit still differs: held level takes the sync value and counter clears.
REQ-012 A sync-level excursion shorter than DEBOUNCE_CYCLES cycles SHALL leave held_out unchanged; any return to the held level SHALL restart the count from 0.
REQ-013 held_out SHALL change exactly DEBOUNCE_CYCLES+2 cycles after the first rising clk_in edge that samples a new, thereafter-stable btn_in value.
REQ-014 press_out[i] SHALL be high for exactly the one cycle in which held_out[i] first reads 1 after reading 0.
  - A release SHALL generate no pulse.
REQ-015 Repeat FSM, per button, states IDLE, DELAY and REPEAT, with one shared-width counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE to DELAY on a held rise; counter cleared.
  - DELAY: counter increments; at REPEAT_DELAY-1, emit a repeat pulse, clear the counter and go to REPEAT.
  - REPEAT: counter increments; at REPEAT_PERIOD-1, emit a repeat pulse and clear the counter.
  - Any state to IDLE when held_out[i]=0; the counter clears and no pulse is emitted that cycle.
REQ-016 step_out[i] SHALL equal press_out[i] OR the repeat pulse[i]; the first repeat SHALL occur REPEAT_DELAY cycles after the press_out pulse, then every REPEAT_PERIOD cycles.
REQ-017 The four channels SHALL be fully independent; simultaneous or opposing buttons SHALL each produce their own pulses with no arbitration.
REQ-018 All outputs SHALL be registered; no combinational path from btn_in to any output.
REQ-019 No counter SHALL wrap: each SHALL clear at its terminal value or on state exit.

Reset
REQ-020 While rst_n_in=0, the following SHALL be 0 immediately and asynchronously:
  - synchronizer flops, held levels and counters;
  - held_out, press_out and step_out;
  - every FSM SHALL be in IDLE.
REQ-021 A button already pressed at reset release SHALL be treated as a new press: press_out SHALL pulse DEBOUNCE_CYCLES+2 cycles after release.
REQ-022 Reset asserted mid-hold or mid-repeat SHALL abort the operation with no further pulses until a new debounced press.

Verification
REQ-023 The bench SHALL use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 and cover these scenarios:
  - Clean press: btn_in[0] rises and holds for 40 cycles -> held_out[0] rises at cycle 6; step_out[0] pulses at cycles 6, 16, 19, 22, ..., 43 and stops on release.
  - Bounce: btn_in[2] toggles with a 3-cycle period for 12 cycles, then holds high -> no press_out pulse during the toggling; exactly one press_out[2] pulse 6 cycles after the final stable high.
  - Short glitch: btn_in[1] high for 3 cycles -> held_out, press_out and step_out stay 0.
  - Simultaneous: btn_in[0] and btn_in[1] rise together -> identical, coincident step_out[1:0] pulse trains.
  - Reset mid-repeat: assert rst_n_in=0 during REPEAT -> all outputs 0 at once; with the button held through release, press_out pulses 6 cycles after release.
  - Release in DELAY: release at cycle 8 after a press -> held_out falls, no repeat pulse, FSM in IDLE.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions four raw push-buttons (bit0=left, bit1=right, bit2=up, bit3=down)
// into clean control strobes. Each channel is independent:
//   2-flop synchronizer -> debounce counter -> registered level / press edge
//   -> auto-repeat FSM (IDLE / DELAY / REPEAT) -> motion-step strobe.
//
// Ports
//   clk_in     : system clock, all state on the rising edge
//   rst_n_in   : asynchronous active-low reset, clears every flop
//   btn_in     : raw asynchronous buttons
//   held_out   : debounced level per button (registered)
//   press_out  : one-cycle pulse when held_out rises (registered)
//   step_out   : press pulse OR auto-repeat pulse (registered)
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int REPEAT_DELAY    = 19500000,
   parameter int REPEAT_PERIOD   = 3250000
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [3:0] btn_in,
   output logic [3:0] held_out,
   output logic [3:0] press_out,
   output logic [3:0] step_out
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
   localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);
   localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);
   localparam logic [RP_W-1:0] RP_ZERO = {RP_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rpt_state_e;

   for (genvar i = 0; i < 4; i++) begin : g_chan
      logic [1:0]      sync_r;
      logic [DB_W-1:0] db_cnt_r;
      logic            held_r;
      logic            held_o_r;
      logic            press_o_r;
      logic            step_o_r;
      rpt_state_e      state_r;
      logic [RP_W-1:0] rp_cnt_r;
      logic            rise_s;

      // held_r is the debounced level one cycle ahead of held_out, so a rise
      // here lines the press pulse up with the first cycle held_out reads 1.
      assign rise_s = held_r & ~held_o_r;

      // Two-flop synchronizer for the asynchronous button input.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            sync_r <= 2'b00;
         end else begin
            sync_r <= {sync_r[0], btn_in[i]};
         end
      end

      // Debounce: count consecutive cycles the synced bit disagrees with the
      // held level; any agreement restarts the count.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            db_cnt_r <= DB_ZERO;
            held_r   <= 1'b0;
         end else if (sync_r[1] == held_r) begin
            db_cnt_r <= DB_ZERO;
         end else if (db_cnt_r == DB_LAST) begin
            held_r   <= sync_r[1];
            db_cnt_r <= DB_ZERO;
         end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
         end
      end

      // Auto-repeat FSM with registered level, press and step outputs.
      // Exit checks use held_r, which is the value held_out takes this edge,
      // so a release never coincides with a stray step.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            state_r   <= ST_IDLE;
            rp_cnt_r  <= RP_ZERO;
            held_o_r  <= 1'b0;
            press_o_r <= 1'b0;
            step_o_r  <= 1'b0;
         end else begin
            held_o_r  <= held_r;
            press_o_r <= rise_s;
            case (state_r)
               ST_IDLE: begin
                  rp_cnt_r <= RP_ZERO;
                  step_o_r <= rise_s;
                  if (held_r) begin
                     state_r <= ST_DELAY;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_DELAY: begin
                  if (!held_r) begin
                     state_r  <= ST_IDLE;
                     rp_cnt_r <= RP_ZERO;
                     step_o_r <= 1'b0;
                  end else if (rp_cnt_r == RD_LAST) begin
                     state_r  <= ST_REPEAT;
                     rp_cnt_r <= RP_ZERO;
                     step_o_r <= 1'b1;
                  end else begin
                     state_r  <= ST_DELAY;
                     rp_cnt_r <= rp_cnt_r + RP_ONE;
                     step_o_r <= rise_s;
                  end
               end
               ST_REPEAT: begin
                  if (!held_r) begin
                     state_r  <= ST_IDLE;
                     rp_cnt_r <= RP_ZERO;
                     step_o_r <= 1'b0;
                  end else if (rp_cnt_r == RP_LAST) begin
                     state_r  <= ST_REPEAT;
                     rp_cnt_r <= RP_ZERO;
                     step_o_r <= 1'b1;
                  end else begin
                     state_r  <= ST_REPEAT;
                     rp_cnt_r <= rp_cnt_r + RP_ONE;
                     step_o_r <= rise_s;
                  end
               end
               default: begin
                  state_r  <= ST_IDLE;
                  rp_cnt_r <= RP_ZERO;
                  step_o_r <= 1'b0;
               end
            endcase
         end
      end

      assign held_out[i]  = held_o_r;
      assign press_out[i] = press_o_r;
      assign step_out[i]  = step_o_r;
   end

endmodule
